frame_sequencer: RTL

//  Per-frame render controller between camera control, matrix_gen, vertex_fetch and the framebuffer.

---
 rtl/frame_sequencer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - per-frame render controller: swap/clear timing, camera/matrix handshake, pixel accounting
module frame_sequencer #(
  parameter int FRAME_PERIOD = 2_000_000,
  parameter int CLEAR_GUARD  = 100,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   ctrl_valid_in,
  input  logic                   matrix_valid_in,
  input  logic                   framebuffer_ready_in,
  input  logic                   pixel_valid_in,
  output logic                   fb_switch_out,
  output logic                   fb_clear_out,
  output logic                   matrix_start_out,
  output logic                   fetch_rst_out,
  output logic                   frame_done_out,
  output logic [COUNT_WIDTH-1:0] pixel_count_out,
  output logic [COUNT_WIDTH-1:0] frame_count_out,
  output logic [COUNT_WIDTH-1:0] skipped_count_out
);

  localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int GW = $clog2(CLEAR_GUARD + 1);

  typedef enum logic [1:0] {
    GUARD    = 2'd0,
    WAIT_CAM = 2'd1,
    WAIT_BUF = 2'd2,
    RENDER   = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [TW-1:0]          timer;
  logic                   swap;
  logic [GW-1:0]          guard, guard_n;
  logic                   pose_pending, pose_n;
  logic                   mat_done, mat_n;
  logic [COUNT_WIDTH-1:0] pix_cnt, pix_n;
  logic [COUNT_WIDTH:0]   pix_sum;
  logic [COUNT_WIDTH-1:0] pix_sat;
  logic                   fetch_n, mstart_n, done_n;
  logic [COUNT_WIDTH-1:0] pixout_n, frame_n, skip_n;

  // Swap fires on the last cycle of each period, independent of the FSM
  assign swap    = (timer == TW'(FRAME_PERIOD - 1));
  assign pix_sum = {1'b0, pix_cnt} + {{COUNT_WIDTH{1'b0}}, pixel_valid_in};
  assign pix_sat = pix_sum[COUNT_WIDTH] ? {COUNT_WIDTH{1'b1}} : pix_sum[COUNT_WIDTH-1:0];

  // Free-running frame timer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      timer <= '0;
    end else if (swap) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state             <= GUARD;
      guard             <= '0;
      pose_pending      <= 1'b0;
      mat_done          <= 1'b0;
      pix_cnt           <= '0;
      fb_switch_out     <= 1'b0;
      fb_clear_out      <= 1'b1;
      matrix_start_out  <= 1'b0;
      fetch_rst_out     <= 1'b1;
      frame_done_out    <= 1'b0;
      pixel_count_out   <= '0;
      frame_count_out   <= '0;
      skipped_count_out <= '0;
    end else begin
      state             <= state_n;
      guard             <= guard_n;
      pose_pending      <= pose_n;
      mat_done          <= mat_n;
      pix_cnt           <= pix_n;
      fb_switch_out     <= swap;
      fb_clear_out      <= swap;
      matrix_start_out  <= mstart_n;
      fetch_rst_out     <= fetch_n;
      frame_done_out    <= done_n;
      pixel_count_out   <= pixout_n;
      frame_count_out   <= frame_n;
      skipped_count_out <= skip_n;
    end
  end

  // Next-state decisions; a swap overrides every other transition
  always_comb begin
    state_n  = state;
    guard_n  = guard;
    pose_n   = pose_pending | ctrl_valid_in;
    mat_n    = mat_done;
    pix_n    = pix_cnt;
    fetch_n  = 1'b1;
    mstart_n = 1'b0;
    done_n   = 1'b0;
    pixout_n = pixel_count_out;
    frame_n  = frame_count_out;
    skip_n   = skipped_count_out;
    if (swap) begin
      state_n = GUARD;
      guard_n = '0;
      if (state == RENDER) begin
        pixout_n = pix_sat;
        frame_n  = frame_count_out + COUNT_WIDTH'(1);
        done_n   = 1'b1;
        pix_n    = '0;
      end else begin
        if (skipped_count_out != {COUNT_WIDTH{1'b1}}) begin
          skip_n = skipped_count_out + COUNT_WIDTH'(1);
        end
        mat_n = 1'b0;
      end
    end else begin
      case (state)
        GUARD: begin
          if (guard == GW'(CLEAR_GUARD - 1)) begin
            state_n = WAIT_CAM;
            guard_n = '0;
          end else begin
            guard_n = guard + GW'(1);
          end
        end
        WAIT_CAM: begin
          if (pose_pending || ctrl_valid_in) begin
            mstart_n = 1'b1;
            // A fresh pose arriving while an older one is consumed stays pending
            pose_n   = pose_pending & ctrl_valid_in;
            mat_n    = 1'b0;
            state_n  = WAIT_BUF;
          end
        end
        WAIT_BUF: begin
          if (matrix_valid_in) begin
            mat_n = 1'b1;
          end
          if ((mat_done || matrix_valid_in) && framebuffer_ready_in) begin
            state_n = RENDER;
            fetch_n = 1'b0;
          end
        end
        RENDER: begin
          fetch_n = 1'b0;
          pix_n   = pix_sat;
        end
        default: state_n = GUARD;
      endcase
    end
  end

endmodule
